// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op and FSM encodings for the sequential ALU
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_EXEC   = 3'd2,
    ST_OUT_LO = 3'd3,
    ST_OUT_HI = 3'd4
  } state_e;

endpackage

// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - operand/result bus between sequencer (master) and ALU (slave)
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic             Begin;
  logic [1:0]       op;
  logic [WIDTH-1:0] inbus;
  logic [WIDTH-1:0] outbus;
  logic             out_valid;
  logic             done;
  logic             busy;
  logic             ovf;
  logic             dz;

  modport master (
    output Begin, op, inbus,
    input  outbus, out_valid, done, busy, ovf, dz
  );

  modport slave (
    input  Begin, op, inbus,
    output outbus, out_valid, done, busy, ovf, dz
  );
endinterface

// File: rtl/alu_seq_iter_core.sv
// rtl/alu_seq_iter_core.sv - iterative shift-add multiply / restoring divide datapath
module alu_seq_iter_core #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [CNT_W-1:0] cnt_init,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt,
  output logic             last
);
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   add_w, part_w, trial_w;

  // Multiply: acc:mq holds the running product, multiplier shifts out LSB first.
  // Divide: acc is the partial remainder, mq shifts dividend out and quotient in.
  assign add_w   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b} : '0);
  assign part_w  = {acc_q, mq_q[WIDTH-1]};
  assign trial_w = part_w - {1'b0, b};

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = '0;
      mq_d  = a;
      cnt_d = cnt_init;
    end else if (step) begin
      cnt_d = cnt_q - 1'b1;
      if (is_div) begin
        if (!trial_w[WIDTH]) begin
          acc_d = trial_w[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = part_w[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_d, mq_d} = {add_w, mq_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mq_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_nxt = acc_d;
  assign mq_nxt  = mq_d;
  assign last    = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - sequential ALU top: FSM, operand capture, add/sub, result output
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            CLk,
  input logic            RST,
  alu_seq_param_if.slave io
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             begin_prev_q, begin_prev_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             res_ovf_q, res_ovf_d, res_dz_q, res_dz_d;
  logic [WIDTH-1:0] outbus_q, outbus_d;
  logic             out_valid_q, out_valid_d, done_q, done_d, busy_q, busy_d;
  logic             ovf_q, ovf_d, dz_q, dz_d;

  logic             start, core_last;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] core_acc, core_mq;
  logic [WIDTH:0]   sum_w, diff_w;

  assign start  = io.Begin && !begin_prev_q;
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};
  // A zero divisor needs only one EXEC cycle, decided while B is still on the bus.
  assign cnt_init = (op_q == OP_ADD || op_q == OP_SUB || (op_q == OP_DIV && io.inbus == '0))
                    ? CNT_W'(1) : CNT_W'(WIDTH);

  alu_seq_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (CLk),
    .rst      (RST),
    .load     (state_q == ST_LOAD_B),
    .step     (state_q == ST_EXEC),
    .is_div   (op_q == OP_DIV),
    .cnt_init (cnt_init),
    .a        (a_q),
    .b        (b_q),
    .acc_nxt  (core_acc),
    .mq_nxt   (core_mq),
    .last     (core_last)
  );

  always_ff @(posedge CLk) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC:   if (core_last) state_d = ST_OUT_LO;
      ST_OUT_LO: state_d = ST_OUT_HI;
      ST_OUT_HI: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    begin_prev_d = io.Begin;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_lo_d     = res_lo_q;
    res_hi_d     = res_hi_q;
    res_ovf_d    = res_ovf_q;
    res_dz_d     = res_dz_q;
    if (state_q == ST_IDLE && start) begin
      op_d = op_e'(io.op);
      a_d  = io.inbus;
    end
    if (state_q == ST_LOAD_B) b_d = io.inbus;
    // Final EXEC cycle: capture the core's post-step values, not its registers.
    if (state_q == ST_EXEC && core_last) begin
      res_ovf_d = 1'b0;
      res_dz_d  = 1'b0;
      case (op_q)
        OP_ADD: begin
          res_lo_d  = sum_w[WIDTH-1:0];
          res_hi_d  = {{(WIDTH-1){1'b0}}, sum_w[WIDTH]};
          res_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          res_lo_d  = diff_w[WIDTH-1:0];
          res_hi_d  = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
          res_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_MUL: begin
          res_lo_d = core_mq;
          res_hi_d = core_acc;
        end
        OP_DIV: begin
          res_dz_d = (b_q == '0);
          res_lo_d = (b_q == '0) ? '1 : core_mq;
          res_hi_d = (b_q == '0) ? a_q : core_acc;
        end
      endcase
    end
  end

  // Output registers trail the state by one cycle.
  always_comb begin
    out_valid_d = (state_q == ST_OUT_LO) || (state_q == ST_OUT_HI);
    done_d      = (state_q == ST_OUT_HI);
    busy_d      = (state_d != ST_IDLE) || done_d;
    outbus_d    = '0;
    if (state_q == ST_OUT_LO)      outbus_d = res_lo_q;
    else if (state_q == ST_OUT_HI) outbus_d = res_hi_q;
    ovf_d = out_valid_d && res_ovf_q;
    dz_d  = out_valid_d && res_dz_q;
  end

  always_ff @(posedge CLk) begin
    if (RST) begin
      begin_prev_q <= 1'b0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      res_lo_q     <= '0;
      res_hi_q     <= '0;
      res_ovf_q    <= 1'b0;
      res_dz_q     <= 1'b0;
      outbus_q     <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      begin_prev_q <= begin_prev_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_lo_q     <= res_lo_d;
      res_hi_q     <= res_hi_d;
      res_ovf_q    <= res_ovf_d;
      res_dz_q     <= res_dz_d;
      outbus_q     <= outbus_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      dz_q         <= dz_d;
    end
  end

  assign io.outbus    = outbus_q;
  assign io.out_valid = out_valid_q;
  assign io.done      = done_q;
  assign io.busy      = busy_q;
  assign io.ovf       = ovf_q;
  assign io.dz        = dz_q;
endmodule
